serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract unit. A single 1-bit full adder is
// reused over WIDTH clock cycles to build a WIDTH-bit result, LSB first.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset, clears all state
//   start  - launch a new operation (accepted only in IDLE or DONE)
//   sub    - 0: a_in + b_in, 1: a_in - b_in (sampled with start)
//   a_in   - operand A (sampled with start)
//   b_in   - operand B (sampled with start)
//   busy   - high while bits are being processed (exactly WIDTH cycles)
//   done   - one-cycle pulse when sum/cout/ovf have just been updated
//   sum    - registered WIDTH-bit two's complement result
//   cout   - carry out of the MSB (for subtract: 1 = no borrow)
//   ovf    - signed overflow of the last operation
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // One extra bit so the counter never wraps inside RUN.
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_sum;
    logic fa_carry;
    logic accept;

    // The shared 1-bit full adder.
    assign fa_sum   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign fa_carry = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);

    assign accept = start && (state_q != StRun);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        if (accept) begin
            // Subtract as A + ~B + 1: invert B and seed the carry with 1.
            state_d = StRun;
            opa_d   = a_in;
            opb_d   = sub ? ~b_in : b_in;
            carry_d = sub;
            cnt_d   = '0;
            part_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StRun: begin
                    opa_d   = opa_q >> 1;
                    opb_d   = opb_q >> 1;
                    part_d  = {fa_sum, part_q[WIDTH-1:1]};
                    carry_d = fa_carry;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        // carry_q is the carry into the MSB here.
                        sum_d   = {fa_sum, part_q[WIDTH-1:1]};
                        cout_d  = fa_carry;
                        ovf_d   = carry_q ^ fa_carry;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
